// File: rtl/sinc_uart_if.sv
// sinc_uart_if -- sample-in / UART-out signal bundle for sinc_uart_tx.
//
//   din      decimated filter word, valid while fbwclk=1
//   fbwclk   single-cycle sample strobe (clkdiv en[2])
//   ovr_clr  clears the sticky overrun flag
//   tx       UART serial line, idles high
//   busy     a frame is being shifted out
//   pend     holding buffer occupied
//   overrun  sticky: a sample was dropped
//
// master: the sample source / observer.  slave: the UART serialiser.
`timescale 1ns/1ps
interface sinc_uart_if #(
    parameter int DW = 16
);
    logic [DW-1:0] din;
    logic          fbwclk;
    logic          ovr_clr;
    logic          tx;
    logic          busy;
    logic          pend;
    logic          overrun;

    modport master (
        output din, fbwclk, ovr_clr,
        input  tx, busy, pend, overrun
    );

    modport slave (
        input  din, fbwclk, ovr_clr,
        output tx, busy, pend, overrun
    );
endinterface

// File: rtl/sinc_uart_tx.sv
// sinc_uart_tx -- serialises decimated sinc filter words as 8N1 UART bytes.
//
// Each 16-bit sample captured on fbwclk is sent MSB byte first; every byte is
// start bit, 8 data bits LSB first, stop bit, each CLKS_PER_BIT clocks long.
// Bytes of one frame, and consecutive frames, follow without idle gap.
// A one-entry holding register absorbs a sample arriving mid-frame; a sample
// arriving while that register is full is dropped and sets sticky overrun.
//
// Optional build macro SINC_UART_SYNC_EN: prefix every frame with 0xA5 so
// the host can resynchronise (3-byte frames).
//
// Ports:
//   clk    system clock
//   rst_n  asynchronous active-low reset
//   bus    sinc_uart_if.slave (din, fbwclk, ovr_clr, tx, busy, pend, overrun)
`timescale 1ns/1ps
module sinc_uart_tx #(
    parameter int CLKS_PER_BIT = 434,
    parameter int DW           = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    sinc_uart_if.slave  bus
);

    localparam int              BCW       = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BCW-1:0]  BAUD_LAST = BCW'(CLKS_PER_BIT - 1);
`ifdef SINC_UART_SYNC_EN
    localparam logic [1:0]      LAST_BYTE = 2'd2;
`else
    localparam logic [1:0]      LAST_BYTE = 2'd1;
`endif

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t          state_q, state_d;
    logic [BCW-1:0]  baud_q, baud_d;
    logic [2:0]      bit_q, bit_d;
    logic [1:0]      byte_q, byte_d;
    logic [DW-1:0]   word_q, word_d;
    logic [DW-1:0]   hold_q, hold_d;
    logic            pend_q, pend_d;
    logic            ovr_q, ovr_d;
    logic            tx_q, tx_d;
    logic            busy_q, busy_d;

    logic            baud_tick;
    logic            take_din;
    logic            take_hold;
    logic            capture;
    logic [7:0]      cur_byte;

    function automatic logic [7:0] byte_sel(input logic [1:0] idx, input logic [DW-1:0] w);
`ifdef SINC_UART_SYNC_EN
        case (idx)
            2'd0:    return 8'hA5;
            2'd1:    return w[15:8];
            default: return w[7:0];
        endcase
`else
        return (idx == 2'd0) ? w[15:8] : w[7:0];
`endif
    endfunction

    always_comb begin
        state_d   = state_q;
        baud_d    = baud_q;
        bit_d     = bit_q;
        byte_d    = byte_q;
        word_d    = word_q;
        hold_d    = hold_q;
        pend_d    = pend_q;
        ovr_d     = ovr_q;
        take_din  = 1'b0;
        take_hold = 1'b0;
        baud_tick = (baud_q == BAUD_LAST);

        case (state_q)
            IDLE: begin
                // Older buffered sample goes first so ordering is preserved.
                if (pend_q)           take_hold = 1'b1;
                else if (bus.fbwclk)  take_din  = 1'b1;
            end
            START: begin
                if (baud_tick) begin
                    state_d = DATA;
                    bit_d   = 3'd0;
                end
            end
            DATA: begin
                if (baud_tick) begin
                    if (bit_q == 3'd7) state_d = STOP;
                    else               bit_d   = bit_q + 3'd1;
                end
            end
            STOP: begin
                if (baud_tick) begin
                    if (byte_q != LAST_BYTE) begin
                        byte_d  = byte_q + 2'd1;
                        state_d = START;
                    end else if (pend_q) begin
                        take_hold = 1'b1;
                    end else if (bus.fbwclk) begin
                        // A strobe on the final stop cycle starts the next
                        // frame directly instead of parking in the buffer.
                        take_din = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Bit timing restarts from zero at every START entry and every tick,
        // so boundaries are exact multiples of CLKS_PER_BIT.
        baud_d = (state_q == IDLE || baud_tick) ? '0 : baud_q + BCW'(1);

        if (take_din || take_hold) begin
            state_d = START;
            byte_d  = 2'd0;
            word_d  = take_hold ? hold_q : bus.din;
        end

        // Holding buffer: a slot freed this cycle may be refilled this cycle.
        capture = bus.fbwclk && !take_din;
        if (capture) begin
            if (!pend_q || take_hold) begin
                hold_d = bus.din;
                pend_d = 1'b1;
            end
        end else if (take_hold) begin
            pend_d = 1'b0;
        end

        if (capture && pend_q && !take_hold) ovr_d = 1'b1;
        else if (bus.ovr_clr)                ovr_d = 1'b0;

        cur_byte = byte_sel(byte_d, word_d);
        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = cur_byte[bit_d];
            default: tx_d = 1'b1;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            byte_q  <= '0;
            word_q  <= '0;
            hold_q  <= '0;
            pend_q  <= 1'b0;
            ovr_q   <= 1'b0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            byte_q  <= byte_d;
            word_q  <= word_d;
            hold_q  <= hold_d;
            pend_q  <= pend_d;
            ovr_q   <= ovr_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
        end
    end

    assign bus.tx      = tx_q;
    assign bus.busy    = busy_q;
    assign bus.pend    = pend_q;
    assign bus.overrun = ovr_q;

endmodule
